// File: rtl/romload_ctrl.sv
// Download-to-ROM loader: buffers index-0 bytes in a 2-entry FIFO toward the ROM target and sequences the core reset.
// Latency: an accepted byte is visible on rom_wr one cycle after its dl_wr strobe.
// Backpressure: dl_wait rises when the FIFO is full; further pushes without a same-cycle pop are dropped and flagged.
module romload_ctrl #(
  parameter int ROM_BYTES   = 65536,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_index,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        rom_wr,
  output logic [24:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_ready,
  output logic        core_reset,
  output logic [7:0]  game_no,
  output logic        load_done,
  output logic        size_err,
  output logic        ovf_err,
  output logic [24:0] byte_count
);

  localparam logic [25:0]   ROM_LIM   = 26'(ROM_BYTES);
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          act_q;
  logic          act_qq;
  logic          rom_valid;
  logic [1:0]    fifo_cnt;
  logic [32:0]   ent0;
  logic [32:0]   ent1;

  logic        rise;
  logic        fall;
  logic        wr_rom;
  logic        in_range;
  logic        push_req;
  logic        push_ok;
  logic        push_drop;
  logic        pop;
  logic [32:0] din;

  // Edges are taken from the registered copy so a glitchy dl_active cannot retrigger within a cycle
  assign rise = act_q & ~act_qq;
  assign fall = ~act_q & act_qq;

  assign wr_rom    = dl_wr & dl_active & (dl_index == 8'd0);
  assign in_range  = {1'b0, dl_addr} < ROM_LIM;
  assign push_req  = wr_rom & in_range;
  assign pop       = (fifo_cnt != 2'd0) & rom_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok   = push_req & ((fifo_cnt != 2'd2) | pop);
  assign push_drop = push_req & ~push_ok;
  assign din       = {dl_addr, dl_data};

  // Outputs toward both sides come straight from FIFO registers, never from inputs
  assign rom_wr   = (fifo_cnt != 2'd0);
  assign dl_wait  = (fifo_cnt == 2'd2);
  assign rom_addr = ent0[32:8];
  assign rom_data = ent0[7:0];

  // Register dl_active twice for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      act_q  <= 1'b0;
      act_qq <= 1'b0;
    end else begin
      act_q  <= dl_active;
      act_qq <= act_q;
    end
  end

  // Two-entry shift FIFO: ent0 is always the head
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt <= 2'd0;
      ent0     <= '0;
      ent1     <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) ent0 <= din;
          else                  ent1 <= din;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          ent0     <= ent1;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // Status: counters and sticky flags restart on each new download; rom_valid survives until reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= '0;
      size_err   <= 1'b0;
      ovf_err    <= 1'b0;
      rom_valid  <= 1'b0;
      game_no    <= 8'd0;
    end else begin
      if (rise) begin
        byte_count <= '0;
        size_err   <= 1'b0;
        ovf_err    <= 1'b0;
      end else begin
        if (push_ok && (byte_count != '1)) byte_count <= byte_count + 25'd1;
        if (push_drop)                     ovf_err    <= 1'b1;
        if (wr_rom && !in_range)           size_err   <= 1'b1;
      end
      if (push_ok) rom_valid <= 1'b1;
      if (dl_wr && (dl_index == 8'd1) && (dl_addr == 25'd0)) game_no <= dl_data;
    end
  end

  // Load sequencer with registered core_reset/load_done; a new download preempts any state
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else if (rise) begin
      state      <= LOAD;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (fall) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_cnt == 2'd0) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            if (rom_valid) begin
              state      <= RUN;
              core_reset <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_romload_ctrl.sv
// Randomized and directed bench for romload_ctrl against a queue-based reference model.
// Outputs are compared at the falling edge; inputs change 1 time unit after the rising edge.
// All comparisons are funnelled through chk().
module tb_romload_ctrl;
  localparam int RB = 16;
  localparam int HC = 5;

  logic        clk_sys   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr     = 1'b0;
  logic [7:0]  dl_index  = 8'd0;
  logic [24:0] dl_addr   = 25'd0;
  logic [7:0]  dl_data   = 8'd0;
  logic        rom_ready = 1'b0;
  logic        dl_wait, rom_wr, core_reset, load_done, size_err, ovf_err;
  logic [24:0] rom_addr, byte_count;
  logic [7:0]  rom_data, game_no;

  romload_ctrl #(.ROM_BYTES(RB), .HOLD_CYCLES(HC)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_index(dl_index), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
    .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ready(rom_ready),
    .core_reset(core_reset), .game_no(game_no), .load_done(load_done),
    .size_err(size_err), .ovf_err(ovf_err), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;

  // Reference model state
  logic [32:0] mq[$];
  logic [24:0] m_bc;
  logic        m_size, m_ovf;
  logic [7:0]  m_game;
  logic        m_a1, m_a2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bc = '0; m_size = 1'b0; m_ovf = 1'b0; m_game = 8'd0;
    m_a1 = 1'b0; m_a2 = 1'b0;
  endtask

  task automatic check_outputs();
    chk("rom_wr", {31'd0, rom_wr}, {31'd0, mq.size() > 0});
    chk("dl_wait", {31'd0, dl_wait}, {31'd0, mq.size() == 2});
    if (mq.size() > 0) begin
      chk("rom_addr", {7'd0, rom_addr}, {7'd0, mq[0][32:8]});
      chk("rom_data", {24'd0, rom_data}, {24'd0, mq[0][7:0]});
    end
    chk("byte_count", {7'd0, byte_count}, {7'd0, m_bc});
    chk("size_err", {31'd0, size_err}, {31'd0, m_size});
    chk("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
    chk("game_no", {24'd0, game_no}, {24'd0, m_game});
  endtask

  // What the next rising edge does with the inputs currently applied
  task automatic model_step();
    logic        rise, pop, req;
    logic [32:0] tmp;
    int          sz;
    rise = m_a1 && !m_a2;
    sz   = mq.size();
    pop  = (sz > 0) && rom_ready;
    req  = dl_wr && dl_active && (dl_index == 8'd0) && (dl_addr < RB);
    if (pop) tmp = mq.pop_front();
    if (req && (sz < 2 || pop)) begin
      mq.push_back({dl_addr, dl_data});
      if (!rise && m_bc != '1) m_bc = m_bc + 25'd1;
    end else if (req && !rise) begin
      m_ovf = 1'b1;
    end
    if (!rise && dl_wr && dl_active && dl_index == 8'd0 && dl_addr >= RB) m_size = 1'b1;
    if (rise) begin
      m_bc = '0; m_size = 1'b0; m_ovf = 1'b0;
    end
    if (dl_wr && dl_index == 8'd1 && dl_addr == 25'd0) m_game = dl_data;
    m_a2 = m_a1;
    m_a1 = dl_active;
  endtask

  task automatic tick();
    @(negedge clk_sys);
    check_outputs();
    if (rom_wr && rom_ready) n_pops++;
    if (reset_n) model_step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_index = idx; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();

    // Reset values
    idle(2);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    reset_n = 1'b1;
    idle(4);
    chk("idle_core_reset", {31'd0, core_reset}, 32'd1);

    // Game-number-only download with no ROM data: back to IDLE, core stays in reset
    dl_active = 1'b1;
    idle(3);
    wr(8'd1, 25'd0, 8'h05);
    wr(8'd1, 25'd3, 8'h09);
    wr(8'd2, 25'd0, 8'hAA);
    idle(1);
    dl_active = 1'b0;
    idle(HC + 8);
    chk("game_only_no", {24'd0, game_no}, 32'h05);
    chk("game_only_core_reset", {31'd0, core_reset}, 32'd1);
    chk("game_only_load_done", {31'd0, load_done}, 32'd0);

    // Basic load of 4 bytes with a ready ROM target
    rom_ready = 1'b1;
    dl_active = 1'b1;
    idle(3);
    n_pops = 0;
    for (int i = 0; i < 4; i++) wr(8'd0, 25'(i), 8'($urandom));
    idle(3);
    chk("basic_pops", n_pops, 32'd4);
    chk("basic_count", {7'd0, byte_count}, 32'd4);
    dl_active = 1'b0;
    n = 0;
    while (core_reset && n < 100) begin
      tick();
      n++;
    end
    chk("basic_release_cycles", n, HC + 3);
    chk("basic_load_done", {31'd0, load_done}, 32'd1);

    // Backpressure: third push into a full FIFO is dropped
    rom_ready = 1'b0;
    dl_active = 1'b1;
    idle(3);
    chk("restart_core_reset", {31'd0, core_reset}, 32'd1);
    chk("restart_load_done", {31'd0, load_done}, 32'd0);
    wr(8'd0, 25'd0, 8'($urandom));
    chk("bp_wait_1", {31'd0, dl_wait}, 32'd0);
    wr(8'd0, 25'd1, 8'($urandom));
    chk("bp_wait_2", {31'd0, dl_wait}, 32'd1);
    wr(8'd0, 25'd2, 8'($urandom));
    chk("bp_ovf", {31'd0, ovf_err}, 32'd1);
    chk("bp_count", {7'd0, byte_count}, 32'd2);
    rom_ready = 1'b1;
    idle(3);
    chk("bp_drained", {31'd0, rom_wr}, 32'd0);

    // Restart while in HOLD: core must never leave reset
    dl_active = 1'b0;
    idle(4);
    dl_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_restart_core_reset", {31'd0, core_reset}, 32'd1);
    end

    // Full FIFO with push and pop in the same cycle
    rom_ready = 1'b0;
    wr(8'd0, 25'd4, 8'($urandom));
    wr(8'd0, 25'd5, 8'($urandom));
    chk("full_wait", {31'd0, dl_wait}, 32'd1);
    rom_ready = 1'b1;
    wr(8'd0, 25'd6, 8'($urandom));
    chk("full_pushpop_wait", {31'd0, dl_wait}, 32'd1);
    chk("full_pushpop_ovf", {31'd0, ovf_err}, 32'd0);
    chk("full_pushpop_count", {7'd0, byte_count}, 32'd3);
    idle(3);

    // Size limit: last legal address accepted, first illegal one dropped
    wr(8'd0, 25'(RB - 1), 8'($urandom));
    wr(8'd0, 25'(RB), 8'($urandom));
    idle(3);
    chk("size_err", {31'd0, size_err}, 32'd1);
    chk("size_count", {7'd0, byte_count}, 32'd4);

    // Randomized traffic in a fresh session
    dl_active = 1'b0;
    idle(12);
    dl_active = 1'b1;
    idle(3);
    for (int i = 0; i < 400; i++) begin
      int pick;
      pick      = int'($urandom_range(0, 4));
      dl_wr     = 1'($urandom_range(0, 1));
      dl_index  = (pick < 3) ? 8'd0 : ((pick == 3) ? 8'd1 : 8'd2);
      dl_addr   = 25'($urandom_range(0, RB + 4));
      dl_data   = 8'($urandom);
      rom_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    dl_wr = 1'b0;
    rom_ready = 1'b1;
    idle(4);

    // Reset in the middle of a load with a full FIFO
    rom_ready = 1'b0;
    wr(8'd0, 25'd1, 8'($urandom));
    wr(8'd0, 25'd2, 8'($urandom));
    chk("pre_reset_wait", {31'd0, dl_wait}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rom_wr", {31'd0, rom_wr}, 32'd0);
    chk("async_dl_wait", {31'd0, dl_wait}, 32'd0);
    chk("async_core_reset", {31'd0, core_reset}, 32'd1);
    chk("async_count", {7'd0, byte_count}, 32'd0);
    chk("async_game_no", {24'd0, game_no}, 32'd0);
    model_reset();
    dl_active = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(HC + 8);
    chk("post_reset_core_reset", {31'd0, core_reset}, 32'd1);
    chk("post_reset_load_done", {31'd0, load_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
